// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle integer ALU, iterative radix-2 multiply/divide unit,
// and the EX/MEM pipeline register with valid tracking, stall and flush.
module ex_stage_md #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 24,
   parameter int MD_EN  = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ex_valid_i,
   input  logic              ex_stall_i,
   input  logic              ex_flush_i,
   input  logic [XLEN-1:0]   ex_port_a_i,
   input  logic [XLEN-1:0]   ex_port_b_i,
   input  logic [3:0]        ex_alu_op_i,
   input  logic              ex_md_en_i,
   input  logic [2:0]        ex_md_op_i,
   input  logic [4:0]        ex_waddr_i,
   input  logic              ex_we_i,
   input  logic [CTRL_W-1:0] ex_ctrl_i,
   output logic [XLEN-1:0]   ex_fwd_dat_o,
   output logic              ex_busy_o,
   output logic              mem_valid_o,
   output logic [XLEN-1:0]   mem_result_o,
   output logic [4:0]        mem_waddr_o,
   output logic              mem_we_o,
   output logic [CTRL_W-1:0] mem_ctrl_o
);

   localparam int SH_W  = $clog2(XLEN);
   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2);
   localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
   localparam bit MD_ON = (MD_EN != 0);

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_DONE
   } md_state_t;

   md_state_t           md_state;
   logic [CNT_W-1:0]    md_cnt;
   logic [2*XLEN-1:0]   md_acc;
   logic [XLEN-1:0]     md_opnd;
   logic [2:0]          md_op;
   logic                md_neg;
   logic                md_neg_rem;
   logic                md_dz;
   logic                md_ovf;

   logic [XLEN-1:0]     alu_res;
   logic [SH_W-1:0]     shamt;
   logic                a_sgn_op;
   logic                b_sgn_op;
   logic                s_a;
   logic                s_b;
   logic                is_div;
   logic [XLEN-1:0]     mag_a;
   logic [XLEN-1:0]     mag_b;
   logic [XLEN-1:0]     start_opnd;
   logic [2*XLEN-1:0]   start_acc;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quo;
   logic [XLEN-1:0]     rem;
   logic [XLEN-1:0]     md_res;
   logic                md_accept;
   logic                md_busy_acc;
   logic                reg_busy;

   // One radix-2 step. Multiply: the low half holds the unconsumed multiplier bits and
   // the high half the running sum. Divide: {remainder, dividend} shifts left, one
   // restoring subtract per step, quotient bits fill in from the bottom.
   function automatic logic [2*XLEN-1:0] md_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   opnd,
                                                 input logic              div);
      logic [XLEN:0] sum;
      logic [XLEN:0] shifted;
      logic [XLEN:0] diff;
      logic [2*XLEN-1:0] nxt;
      if (div) begin
         shifted = acc[2*XLEN-1:XLEN-1];
         diff    = shifted - {1'b0, opnd};
         if (!diff[XLEN])
            nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
         nxt = {sum, acc[XLEN-1:1]};
      end
      return nxt;
   endfunction

   assign shamt = ex_port_b_i[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      case (ex_alu_op_i)
         4'd0:    alu_res = ex_port_a_i + ex_port_b_i;
         4'd1:    alu_res = ex_port_a_i - ex_port_b_i;
         4'd2:    alu_res = ex_port_a_i << shamt;
         4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(ex_port_a_i) < $signed(ex_port_b_i))};
         4'd4:    alu_res = {{(XLEN-1){1'b0}}, (ex_port_a_i < ex_port_b_i)};
         4'd5:    alu_res = ex_port_a_i ^ ex_port_b_i;
         4'd6:    alu_res = ex_port_a_i >> shamt;
         4'd7:    alu_res = $signed(ex_port_a_i) >>> shamt;
         4'd8:    alu_res = ex_port_a_i | ex_port_b_i;
         4'd9:    alu_res = ex_port_a_i & ex_port_b_i;
         4'd10:   alu_res = ex_port_b_i;
         default: alu_res = '0;
      endcase
   end

   // Operands are iterated as magnitudes; signs are folded back in at DONE.
   // The first iteration is applied while latching so DONE lands on cycle XLEN.
   always_comb begin
      a_sgn_op   = (ex_md_op_i == 3'd1) || (ex_md_op_i == 3'd2) ||
                   (ex_md_op_i == 3'd4) || (ex_md_op_i == 3'd6);
      b_sgn_op   = (ex_md_op_i == 3'd1) || (ex_md_op_i == 3'd4) || (ex_md_op_i == 3'd6);
      s_a        = a_sgn_op & ex_port_a_i[XLEN-1];
      s_b        = b_sgn_op & ex_port_b_i[XLEN-1];
      mag_a      = s_a ? -ex_port_a_i : ex_port_a_i;
      mag_b      = s_b ? -ex_port_b_i : ex_port_b_i;
      is_div     = ex_md_op_i[2];
      start_opnd = is_div ? mag_b : mag_a;
      start_acc  = md_step(is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b},
                           start_opnd, is_div);
   end

   assign md_busy_acc = MD_ON && (md_state == MD_IDLE) && ex_valid_i && ex_md_en_i;
   assign md_accept   = md_busy_acc && !ex_flush_i;
   assign reg_busy    = md_busy_acc || (md_state == MD_RUN);
   assign ex_busy_o   = reg_busy || ((md_state == MD_DONE) && ex_stall_i);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         md_state   <= MD_IDLE;
         md_cnt     <= '0;
         md_acc     <= '0;
         md_opnd    <= '0;
         md_op      <= '0;
         md_neg     <= 1'b0;
         md_neg_rem <= 1'b0;
         md_dz      <= 1'b0;
         md_ovf     <= 1'b0;
      end else begin
         case (md_state)
            MD_IDLE: begin
               if (md_accept) begin
                  md_state   <= MD_RUN;
                  md_cnt     <= CNT_START;
                  md_acc     <= start_acc;
                  md_opnd    <= start_opnd;
                  md_op      <= ex_md_op_i;
                  md_neg     <= s_a ^ s_b;
                  md_neg_rem <= s_a;
                  md_dz      <= (ex_port_b_i == '0);
                  md_ovf     <= ((ex_md_op_i == 3'd4) || (ex_md_op_i == 3'd6)) &&
                                (ex_port_a_i == MIN_NEG) && (ex_port_b_i == '1);
               end
            end
            MD_RUN: begin
               if (ex_flush_i) begin
                  md_state <= MD_IDLE;
                  md_cnt   <= '0;
               end else begin
                  md_acc <= md_step(md_acc, md_opnd, md_op[2]);
                  md_cnt <= md_cnt - CNT_W'(1);
                  if (md_cnt == CNT_LAST)
                     md_state <= MD_DONE;
               end
            end
            MD_DONE: begin
               if (ex_flush_i || !ex_stall_i) begin
                  md_state <= MD_IDLE;
                  md_cnt   <= '0;
               end
            end
            default: begin
               md_state <= MD_IDLE;
               md_cnt   <= '0;
            end
         endcase
      end
   end

   // Sign correction and the divide-by-zero / overflow overrides.
   always_comb begin
      prod   = md_neg ? -md_acc : md_acc;
      quo    = md_acc[XLEN-1:0];
      rem    = md_acc[2*XLEN-1:XLEN];
      md_res = '0;
      case (md_op)
         3'd0:    md_res = prod[XLEN-1:0];
         3'd4:    md_res = md_dz ? '1 : (md_ovf ? MIN_NEG : (md_neg ? -quo : quo));
         3'd5:    md_res = md_dz ? '1 : quo;
         3'd6:    md_res = md_ovf ? '0 : (md_neg_rem ? -rem : rem);
         3'd7:    md_res = rem;
         default: md_res = prod[2*XLEN-1:XLEN];
      endcase
   end

   always_comb begin
      ex_fwd_dat_o = alu_res;
      if (md_state == MD_DONE)
         ex_fwd_dat_o = md_res;
      else if (!MD_ON && ex_md_en_i)
         ex_fwd_dat_o = '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_valid_o  <= 1'b0;
         mem_result_o <= '0;
         mem_waddr_o  <= '0;
         mem_we_o     <= 1'b0;
         mem_ctrl_o   <= '0;
      end else if (ex_flush_i || (!ex_stall_i && reg_busy)) begin
         mem_valid_o  <= 1'b0;
         mem_result_o <= '0;
         mem_waddr_o  <= '0;
         mem_we_o     <= 1'b0;
         mem_ctrl_o   <= '0;
      end else if (!ex_stall_i) begin
         mem_valid_o  <= ex_valid_i;
         mem_result_o <= ex_fwd_dat_o;
         mem_waddr_o  <= ex_waddr_i;
         mem_we_o     <= ex_we_i & ex_valid_i;
         mem_ctrl_o   <= ex_ctrl_i;
      end
   end

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed literal results.
module tb_ex_stage_md;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 24;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              ex_valid_i;
   logic              ex_stall_i;
   logic              ex_flush_i;
   logic [XLEN-1:0]   ex_port_a_i;
   logic [XLEN-1:0]   ex_port_b_i;
   logic [3:0]        ex_alu_op_i;
   logic              ex_md_en_i;
   logic [2:0]        ex_md_op_i;
   logic [4:0]        ex_waddr_i;
   logic              ex_we_i;
   logic [CTRL_W-1:0] ex_ctrl_i;
   logic [XLEN-1:0]   ex_fwd_dat_o;
   logic              ex_busy_o;
   logic              mem_valid_o;
   logic [XLEN-1:0]   mem_result_o;
   logic [4:0]        mem_waddr_o;
   logic              mem_we_o;
   logic [CTRL_W-1:0] mem_ctrl_o;

   int errors = 0;
   int checks = 0;

   ex_stage_md #(.XLEN(XLEN), .CTRL_W(CTRL_W), .MD_EN(1)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .ex_valid_i   (ex_valid_i),
      .ex_stall_i   (ex_stall_i),
      .ex_flush_i   (ex_flush_i),
      .ex_port_a_i  (ex_port_a_i),
      .ex_port_b_i  (ex_port_b_i),
      .ex_alu_op_i  (ex_alu_op_i),
      .ex_md_en_i   (ex_md_en_i),
      .ex_md_op_i   (ex_md_op_i),
      .ex_waddr_i   (ex_waddr_i),
      .ex_we_i      (ex_we_i),
      .ex_ctrl_i    (ex_ctrl_i),
      .ex_fwd_dat_o (ex_fwd_dat_o),
      .ex_busy_o    (ex_busy_o),
      .mem_valid_o  (mem_valid_o),
      .mem_result_o (mem_result_o),
      .mem_waddr_o  (mem_waddr_o),
      .mem_we_o     (mem_we_o),
      .mem_ctrl_o   (mem_ctrl_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << b[4:0];
         4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:    return (a < b) ? 32'd1 : 32'd0;
         4'd5:    return a ^ b;
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         4'd8:    return a | b;
         4'd9:    return a & b;
         4'd10:   return b;
         default: return 32'd0;
      endcase
   endfunction

   // RV32M results from plain 64-bit arithmetic.
   function automatic logic [31:0] mdRef(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ub, q;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'h0, b});
      case (op)
         3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            q = sa / sb;
            return q[31:0];
         end
         3'd5: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 32'h0) return a;
            q = sa % sb;
            return q[31:0];
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   // Reference pipeline state: EX/MEM contents plus an outstanding md op that
   // becomes available XLEN cycles after acceptance.
   logic              m_valid = 1'b0;
   logic              m_we = 1'b0;
   logic [31:0]       m_result = '0;
   logic [4:0]        m_waddr = '0;
   logic [CTRL_W-1:0] m_ctrl = '0;
   bit                md_active = 1'b0;
   int                md_left = 0;
   logic [31:0]       md_result = '0;

   function automatic bit mdReady();
      return md_active && (md_left == 0);
   endfunction

   function automatic bit expRegBusy();
      return (!md_active && ex_valid_i && ex_md_en_i) || (md_active && md_left > 0);
   endfunction

   function automatic logic [31:0] expFwd();
      return mdReady() ? md_result : aluRef(ex_alu_op_i, ex_port_a_i, ex_port_b_i);
   endfunction

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m_valid   <= 1'b0;
         m_we      <= 1'b0;
         m_result  <= '0;
         m_waddr   <= '0;
         m_ctrl    <= '0;
         md_active <= 1'b0;
         md_left   <= 0;
         md_result <= '0;
      end else begin
         if (ex_flush_i || (!ex_stall_i && expRegBusy())) begin
            m_valid  <= 1'b0;
            m_we     <= 1'b0;
            m_result <= '0;
            m_waddr  <= '0;
            m_ctrl   <= '0;
         end else if (!ex_stall_i) begin
            m_valid  <= ex_valid_i;
            m_we     <= ex_we_i && ex_valid_i;
            m_result <= expFwd();
            m_waddr  <= ex_waddr_i;
            m_ctrl   <= ex_ctrl_i;
         end
         if (md_active) begin
            if (ex_flush_i)
               md_active <= 1'b0;
            else if (md_left > 0)
               md_left <= md_left - 1;
            else if (!ex_stall_i)
               md_active <= 1'b0;
         end else if (ex_valid_i && ex_md_en_i && !ex_flush_i) begin
            md_active <= 1'b1;
            md_left   <= XLEN - 1;
            md_result <= mdRef(ex_md_op_i, ex_port_a_i, ex_port_b_i);
         end
      end
   end

   always @(negedge clk_i) begin
      checkOutput("cmp_mem_valid", mem_valid_o, m_valid);
      checkOutput("cmp_mem_we", mem_we_o, m_we);
      checkOutput("cmp_mem_result", mem_result_o, m_result);
      checkOutput("cmp_mem_waddr", mem_waddr_o, m_waddr);
      checkOutput("cmp_mem_ctrl", mem_ctrl_o, m_ctrl);
      checkOutput("cmp_busy", ex_busy_o, expRegBusy() || (mdReady() && ex_stall_i));
      checkOutput("cmp_fwd", ex_fwd_dat_o, expFwd());
   end

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic applyStimulus(input bit valid, input bit md_en, input logic [3:0] alu_op,
                                input logic [2:0] md_op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] waddr, input bit we,
                                input logic [CTRL_W-1:0] ctrl);
      ex_valid_i  = valid;
      ex_md_en_i  = md_en;
      ex_alu_op_i = alu_op;
      ex_md_op_i  = md_op;
      ex_port_a_i = a;
      ex_port_b_i = b;
      ex_waddr_i  = waddr;
      ex_we_i     = we;
      ex_ctrl_i   = ctrl;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 4'd0, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, '0);
   endtask

   // Issue one md op, wait for it to land in MEM, and pin latency and result.
   task automatic runMd(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int lat;
      applyStimulus(1'b1, 1'b1, 4'd0, op, a, b, 5'd11, 1'b1, 24'h00C0DE);
      #1;
      checkOutput({name, "_busy_c0"}, ex_busy_o, 1'b1);
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 31) checkOutput({name, "_busy_c31"}, ex_busy_o, 1'b1);
         if (lat == 32) checkOutput({name, "_busy_c32"}, ex_busy_o, 1'b0);
      end while (!mem_valid_o && lat < 40);
      checkOutput({name, "_latency"}, lat, XLEN + 1);
      checkOutput({name, "_result"}, mem_result_o, exp);
      checkOutput({name, "_we"}, mem_we_o, 1'b1);
      applyIdle();
   endtask

   logic [3:0]  tOp  [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
   logic [31:0] tA   [11] = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                              32'h80000000, 32'h80000000, 32'h12340000, 32'hFFFF0000,
                              32'h0, 32'd5};
   logic [31:0] tB   [11] = '{32'd7, 32'h24, 32'h0, 32'h0, 32'hFF00FF00, 32'd31, 32'd4,
                              32'h00005678, 32'h12345678, 32'hDEADBEEF, 32'd6};
   logic [31:0] tExp [11] = '{32'hFFFFFFFE, 32'd16, 32'd1, 32'd0, 32'h0FF00FF0, 32'd1,
                              32'hF8000000, 32'h12345678, 32'h12340000, 32'hDEADBEEF, 32'd0};

   initial begin
      rst_i      = 1'b0;
      ex_stall_i = 1'b0;
      ex_flush_i = 1'b0;
      applyIdle();
      tick();
      tick();
      checkOutput("reset_valid", mem_valid_o, 1'b0);
      checkOutput("reset_result", mem_result_o, 32'h0);
      checkOutput("reset_waddr", mem_waddr_o, 5'd0);
      checkOutput("reset_we", mem_we_o, 1'b0);
      checkOutput("reset_ctrl", mem_ctrl_o, 24'h0);
      checkOutput("reset_busy", ex_busy_o, 1'b0);
      rst_i = 1'b1;
      tick();

      applyStimulus(1'b1, 1'b0, 4'd0, 3'd0, 32'd5, 32'd7, 5'd3, 1'b1, 24'hABCDE);
      #1;
      checkOutput("add_fwd", ex_fwd_dat_o, 32'd12);
      tick();
      checkOutput("add_valid", mem_valid_o, 1'b1);
      checkOutput("add_result", mem_result_o, 32'd12);
      checkOutput("add_waddr", mem_waddr_o, 5'd3);
      checkOutput("add_we", mem_we_o, 1'b1);
      checkOutput("add_ctrl", mem_ctrl_o, 24'hABCDE);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, 1'b0, tOp[i], 3'd0, tA[i], tB[i], 5'(i + 1), 1'b1, 24'(i));
         #1;
         checkOutput($sformatf("alu%0d_fwd", i), ex_fwd_dat_o, tExp[i]);
         tick();
         checkOutput($sformatf("alu%0d_mem", i), mem_result_o, tExp[i]);
      end

      applyStimulus(1'b0, 1'b0, 4'd0, 3'd0, 32'd1, 32'd2, 5'd9, 1'b1, 24'h1);
      tick();
      checkOutput("invalid_we", mem_we_o, 1'b0);
      checkOutput("invalid_valid", mem_valid_o, 1'b0);
      applyIdle();
      tick();

      runMd("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
      runMd("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      runMd("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      runMd("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);
      runMd("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      runMd("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
      runMd("divu_dz", 3'd5, 32'd9, 32'd0, 32'hFFFFFFFF);
      runMd("remu_dz", 3'd7, 32'd9, 32'd0, 32'd9);
      runMd("div_dz", 3'd4, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
      runMd("rem_dz", 3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
      runMd("rem_neg", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
      runMd("divu", 3'd5, 32'd100, 32'd7, 32'd14);

      // DIV -7/2 held in DONE by a three-cycle downstream stall.
      applyStimulus(1'b1, 1'b1, 4'd0, 3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, 1'b1, 24'h777);
      repeat (32) tick();
      #1;
      checkOutput("stall_done_fwd", ex_fwd_dat_o, 32'hFFFFFFFD);
      checkOutput("stall_done_busy", ex_busy_o, 1'b0);
      ex_stall_i = 1'b1;
      #1;
      checkOutput("stall_busy_now", ex_busy_o, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("stall_busy%0d", i), ex_busy_o, 1'b1);
         checkOutput($sformatf("stall_hold%0d", i), mem_valid_o, 1'b0);
      end
      ex_stall_i = 1'b0;
      tick();
      checkOutput("stall_release_valid", mem_valid_o, 1'b1);
      checkOutput("stall_release_result", mem_result_o, 32'hFFFFFFFD);
      checkOutput("stall_release_waddr", mem_waddr_o, 5'd7);
      applyIdle();
      tick();

      // Flush during RUN, then an ordinary ADD.
      applyStimulus(1'b1, 1'b1, 4'd0, 3'd0, 32'd3, 32'd5, 5'd9, 1'b1, 24'h99);
      repeat (10) tick();
      ex_flush_i = 1'b1;
      tick();
      ex_flush_i = 1'b0;
      applyStimulus(1'b1, 1'b0, 4'd0, 3'd0, 32'd1, 32'd1, 5'd4, 1'b1, 24'h44);
      #1;
      checkOutput("flush_busy", ex_busy_o, 1'b0);
      checkOutput("flush_valid", mem_valid_o, 1'b0);
      tick();
      checkOutput("post_flush_valid", mem_valid_o, 1'b1);
      checkOutput("post_flush_result", mem_result_o, 32'd2);
      checkOutput("post_flush_waddr", mem_waddr_o, 5'd4);

      // Asynchronous reset while an md op runs under a stall holding MEM.
      applyStimulus(1'b1, 1'b0, 4'd0, 3'd0, 32'd1, 32'd1, 5'd5, 1'b1, 24'h123456);
      tick();
      ex_stall_i = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'd0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 1'b1, 24'h1);
      repeat (5) tick();
      checkOutput("run_hold_valid", mem_valid_o, 1'b1);
      checkOutput("run_hold_result", mem_result_o, 32'd2);
      checkOutput("run_hold_busy", ex_busy_o, 1'b1);
      ex_stall_i = 1'b0;
      applyIdle();
      rst_i = 1'b0;
      #1;
      checkOutput("async_rst_valid", mem_valid_o, 1'b0);
      checkOutput("async_rst_result", mem_result_o, 32'h0);
      checkOutput("async_rst_waddr", mem_waddr_o, 5'd0);
      checkOutput("async_rst_we", mem_we_o, 1'b0);
      checkOutput("async_rst_ctrl", mem_ctrl_o, 24'h0);
      checkOutput("async_rst_busy", ex_busy_o, 1'b0);
      tick();
      rst_i = 1'b1;
      tick();
      runMd("mul_after_rst", 3'd0, 32'd6, 32'd7, 32'd42);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
